// File: rtl/io_pwr_seq.sv
// io_pwr_seq: IO-ring supply sequencer; 2-flop sync + debounce of pwr_ok, then staged retention release/pad enables.
// Registered outputs, no backpressure; define IO_PWR_SEQ_FAULT_EN for the sticky supply-loss FAULT state.
`timescale 1ns/1ps
module io_pwr_seq #(
  parameter int DEB_CYC = 8,
  parameter int SEQ_DLY = 4,
  parameter int N_GRP   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwr_ok_raw,
  input  logic             seq_start,
  input  logic             fault_clr,
  output logic [N_GRP-1:0] pad_en,
  output logic             pad_ret,
  output logic             seq_done,
  output logic             pwr_fault
);

  localparam int CMAX = (DEB_CYC > SEQ_DLY) ? DEB_CYC : SEQ_DLY;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYC - 1);
  localparam logic [CW-1:0] SEQ_LAST = CW'(SEQ_DLY - 1);

  typedef enum logic [2:0] {
    S_OFF, S_DEB, S_RET, S_EN, S_UP, S_DOWN, S_FAULT
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [N_GRP-1:0] pad_en_q;
  logic             pad_ret_q;
  logic             seq_done_q;
  logic             pwr_fault_q;
  logic             sync1_q;
  logic             pwr_ok_s_q;
  logic             pok_prev_q;

  logic [N_GRP-1:0] pad_en_up_d;
  logic [N_GRP-1:0] pad_en_dn_d;
  logic             fault_trip;
  logic             supply_soft_loss;
  logic             clr_req;
  logic             stop_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      pwr_ok_s_q <= 1'b0;
      pok_prev_q <= 1'b0;
    end else begin
      sync1_q    <= pwr_ok_raw;
      pwr_ok_s_q <= sync1_q;
      pok_prev_q <= pwr_ok_s_q;
    end
  end

`ifdef IO_PWR_SEQ_FAULT_EN
  assign fault_trip       = !pwr_ok_s_q && (state_q inside {S_RET, S_EN, S_UP, S_DOWN});
  assign supply_soft_loss = 1'b0;
  assign clr_req          = fault_clr;
`else
  // Without the fault state a supply drop just unwinds the ring in order.
  assign fault_trip       = 1'b0;
  assign supply_soft_loss = !pwr_ok_s_q;
  assign clr_req          = 1'b0;
  wire   unused_fault_clr = fault_clr;
`endif

  assign stop_req    = !seq_start || supply_soft_loss;
  assign pad_en_up_d = (pad_en_q << 1) | N_GRP'(1);
  assign pad_en_dn_d = pad_en_q >> 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_OFF;
      cnt_q       <= '0;
      pad_en_q    <= '0;
      pad_ret_q   <= 1'b1;
      seq_done_q  <= 1'b0;
      pwr_fault_q <= 1'b0;
    end else begin
      cnt_q <= '0;
      if (fault_trip) begin
        state_q     <= S_FAULT;
        pad_en_q    <= '0;
        pad_ret_q   <= 1'b1;
        seq_done_q  <= 1'b0;
        pwr_fault_q <= 1'b1;
      end else begin
        unique case (state_q)
          S_OFF: begin
            if (pwr_ok_s_q && seq_start) state_q <= S_DEB;
          end
          S_DEB: begin
            // A high cycle counts only once pwr_ok_s was also high on the previous edge.
            if (!seq_start) begin
              state_q <= S_OFF;
            end else if (pwr_ok_s_q && pok_prev_q) begin
              if (cnt_q == DEB_LAST) begin
                state_q   <= S_RET;
                pad_ret_q <= 1'b0;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
          end
          S_RET: begin
            if (stop_req) begin
              state_q <= S_DOWN;
            end else if (cnt_q == SEQ_LAST) begin
              state_q  <= S_EN;
              pad_en_q <= N_GRP'(1);
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_EN: begin
            if (stop_req) begin
              state_q <= S_DOWN;
            end else if (cnt_q == SEQ_LAST) begin
              if (pad_en_q[N_GRP-1]) begin
                state_q    <= S_UP;
                seq_done_q <= 1'b1;
              end else begin
                pad_en_q <= pad_en_up_d;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_UP: begin
            if (stop_req) begin
              state_q    <= S_DOWN;
              seq_done_q <= 1'b0;
            end
          end
          S_DOWN: begin
            // Enables are a contiguous run from bit 0, so a right shift drops the highest one.
            if (cnt_q == SEQ_LAST) begin
              if (pad_en_q != '0) begin
                pad_en_q <= pad_en_dn_d;
              end else begin
                state_q   <= S_OFF;
                pad_ret_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_FAULT: begin
            if (clr_req) begin
              state_q     <= S_OFF;
              pwr_fault_q <= 1'b0;
            end
          end
          default: state_q <= S_OFF;
        endcase
      end
    end
  end

  assign pad_en    = pad_en_q;
  assign pad_ret   = pad_ret_q;
  assign seq_done  = seq_done_q;
  assign pwr_fault = pwr_fault_q;

endmodule

// File: tb/tb_io_pwr_seq.sv
// Scoreboard bench for io_pwr_seq: stimulus queues expected output changes, a negedge monitor pops on every change.
`timescale 1ns/1ps
module tb_io_pwr_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       pwr_ok_raw;
  logic       seq_start;
  logic       fault_clr;
  logic [3:0] pad_en;
  logic       pad_ret;
  logic       seq_done;
  logic       pwr_fault;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct packed {
    int         edge_n;
    logic [6:0] v;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  io_pwr_seq #(.DEB_CYC(8), .SEQ_DLY(4), .N_GRP(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .pwr_ok_raw (pwr_ok_raw),
    .seq_start  (seq_start),
    .fault_clr  (fault_clr),
    .pad_en     (pad_en),
    .pad_ret    (pad_ret),
    .seq_done   (seq_done),
    .pwr_fault  (pwr_fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(string nm, int e, logic [3:0] en, logic ret, logic done, logic flt);
    exp_t x;
    x.edge_n = e;
    x.v      = {en, ret, done, flt};
    exp_q.push_back(x);
    name_q.push_back(nm);
  endfunction

  function automatic void push_ramp(string tag, int r);
    push({tag, "_ret0"}, r,      4'b0000, 1'b0, 1'b0, 1'b0);
    push({tag, "_en1"},  r + 4,  4'b0001, 1'b0, 1'b0, 1'b0);
    push({tag, "_en2"},  r + 8,  4'b0011, 1'b0, 1'b0, 1'b0);
    push({tag, "_en3"},  r + 12, 4'b0111, 1'b0, 1'b0, 1'b0);
    push({tag, "_en4"},  r + 16, 4'b1111, 1'b0, 1'b0, 1'b0);
    push({tag, "_done"}, r + 20, 4'b1111, 1'b0, 1'b1, 1'b0);
  endfunction

  // Monitor: any change of the output vector is one DUT event, matched against the queue head.
  logic [6:0] prev = 7'b0000_1_0_0;
  always @(negedge clk) begin
    logic [6:0] cur;
    exp_t       e;
    string      nm;
    cur = {pad_en, pad_ret, seq_done, pwr_fault};
    if (cur !== prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_change: got %b at edge %0d, required no change", cur, cyc);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (cur !== e.v || cyc != e.edge_n) begin
          fails++;
          $display("FAIL %s: got {en,ret,done,flt}=%b at edge %0d, required %b at edge %0d",
                   nm, cur, cyc, e.v, e.edge_n);
        end
      end
      prev = cur;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic until_edge(int e);
    while (cyc < e) step();
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic drain(string nm, int limit);
    int k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      step();
      k++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d expected events still pending, required 0", nm, exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int d;
    int f;
    rst        = 1'b1;
    pwr_ok_raw = 1'b0;
    seq_start  = 1'b0;
    fault_clr  = 1'b0;
    #1;
    chk("rst_pad_en",    32'(pad_en),    32'h0);
    chk("rst_pad_ret",   32'(pad_ret),   32'h1);
    chk("rst_seq_done",  32'(seq_done),  32'h0);
    chk("rst_pwr_fault", 32'(pwr_fault), 32'h0);
    repeat (3) step();
    rst = 1'b0;
    repeat (40) step();
    chk("idle_pad_en",    32'(pad_en),    32'h0);
    chk("idle_pad_ret",   32'(pad_ret),   32'h1);
    chk("idle_seq_done",  32'(seq_done),  32'h0);
    chk("idle_pwr_fault", 32'(pwr_fault), 32'h0);

    // Clean power-up: edge 0 is the next edge.
    t0 = cyc + 1;
    pwr_ok_raw = 1'b1;
    seq_start  = 1'b1;
    push_ramp("up", t0 + 10);
    drain("up", 45);

    // Requested power-down from UP.
    d = cyc + 1;
    seq_start = 1'b0;
    push("dn_done0", d,      4'b1111, 1'b0, 1'b0, 1'b0);
    push("dn_en3",   d + 4,  4'b0111, 1'b0, 1'b0, 1'b0);
    push("dn_en2",   d + 8,  4'b0011, 1'b0, 1'b0, 1'b0);
    push("dn_en1",   d + 12, 4'b0001, 1'b0, 1'b0, 1'b0);
    push("dn_en0",   d + 16, 4'b0000, 1'b0, 1'b0, 1'b0);
    push("dn_ret1",  d + 20, 4'b0000, 1'b1, 1'b0, 1'b0);
    drain("dn", 30);

    // Power-up with a one-cycle supply glitch sampled at edge 5.
    pwr_ok_raw = 1'b0;
    repeat (4) step();
    t0 = cyc + 1;
    pwr_ok_raw = 1'b1;
    seq_start  = 1'b1;
    push_ramp("glitch", t0 + 16);
    until_edge(t0 + 4);
    pwr_ok_raw = 1'b0;
    step();
    pwr_ok_raw = 1'b1;
    drain("glitch", 50);

    // Supply loss while UP, then fault_clr pulse and restart.
    f = cyc + 1;
    pwr_ok_raw = 1'b0;
`ifdef IO_PWR_SEQ_FAULT_EN
    push("flt_set", f + 2, 4'b0000, 1'b1, 1'b0, 1'b1);
`else
    push("loss_done0", f + 2,  4'b1111, 1'b0, 1'b0, 1'b0);
    push("loss_en3",   f + 6,  4'b0111, 1'b0, 1'b0, 1'b0);
    push("loss_en2",   f + 10, 4'b0011, 1'b0, 1'b0, 1'b0);
    push("loss_en1",   f + 14, 4'b0001, 1'b0, 1'b0, 1'b0);
    push("loss_en0",   f + 18, 4'b0000, 1'b0, 1'b0, 1'b0);
    push("loss_ret1",  f + 22, 4'b0000, 1'b1, 1'b0, 1'b0);
`endif
    until_edge(f + 5);
    fault_clr = 1'b1;
`ifdef IO_PWR_SEQ_FAULT_EN
    push("flt_clr", f + 6, 4'b0000, 1'b1, 1'b0, 1'b0);
`endif
    step();
    fault_clr = 1'b0;
    until_edge(f + 25);
    pwr_ok_raw = 1'b1;
    push_ramp("restart", f + 26 + 10);
    drain("restart", 80);

    // Asynchronous reset from UP, mid-cycle.
    push("arst", cyc, 4'b0000, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("arst_pad_en",   32'(pad_en),   32'h0);
    chk("arst_pad_ret",  32'(pad_ret),  32'h1);
    chk("arst_seq_done", 32'(seq_done), 32'h0);
    seq_start  = 1'b0;
    pwr_ok_raw = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    repeat (5) step();
    drain("arst", 5);

    // Abort during ENABLE: only the two enabled groups unwind.
    t0 = cyc + 1;
    pwr_ok_raw = 1'b1;
    seq_start  = 1'b1;
    push("ab_ret0", t0 + 10, 4'b0000, 1'b0, 1'b0, 1'b0);
    push("ab_en1",  t0 + 14, 4'b0001, 1'b0, 1'b0, 1'b0);
    push("ab_en2",  t0 + 18, 4'b0011, 1'b0, 1'b0, 1'b0);
    until_edge(t0 + 19);
    seq_start = 1'b0;
    push("ab_dn1",  t0 + 24, 4'b0001, 1'b0, 1'b0, 1'b0);
    push("ab_dn0",  t0 + 28, 4'b0000, 1'b0, 1'b0, 1'b0);
    push("ab_ret1", t0 + 32, 4'b0000, 1'b1, 1'b0, 1'b0);
    drain("abort", 40);
    repeat (10) step();
    chk("end_pad_en",  32'(pad_en),  32'h0);
    chk("end_pad_ret", 32'(pad_ret), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
